// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared select encoding and helpers for the program-counter unit
package pc_pkg;

  localparam logic [2:0] SEL_WR   = 3'd0;
  localparam logic [2:0] SEL_RET  = 3'd1;
  localparam logic [2:0] SEL_CALL = 3'd2;
  localparam logic [2:0] SEL_BR   = 3'd3;
  localparam logic [2:0] SEL_SEQ  = 3'd4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;
  logic [PW-1:0]    w_top_idx;

  // r_ptr names the next free slot, so the newest entry sits one below it
  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (PW+1)'(DEPTH));
  assign overflow  = push & full;
  assign underflow = pop & empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full) r_cnt <= r_cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with return-address stack and alignment check
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mod_en,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  input  logic             ib,
  input  logic [WIDTH-1:0] bv,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] iaddrout,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MASK_W = STEP_W - WIDTH'(1);

  logic [WIDTH-1:0] r_ctr;
  logic [WIDTH-1:0] r_iaddr;
  logic             r_err;
  logic             r_misalign;

  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_br;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf;
  logic             w_udf;
  logic             w_conflict;

  assign w_seq = r_ctr + STEP_W;
  assign w_br  = r_ctr + bv;

  always_comb begin
    w_sel = SEL_SEQ;
    if (we)        w_sel = SEL_WR;
    else if (ret)  w_sel = SEL_RET;
    else if (call) w_sel = SEL_CALL;
    else if (ib)   w_sel = SEL_BR;
  end

  always_comb begin
    w_next = w_seq;
    case (w_sel)
      SEL_WR:   w_next = wd;
      SEL_RET:  w_next = ras_empty ? w_seq : w_top;
      SEL_CALL: w_next = w_br;
      SEL_BR:   w_next = w_br;
      default:  w_next = w_seq;
    endcase
  end

  // the stack only moves on enabled updates, so a stall cannot leak a push or pop
  assign w_push     = mod_en & (w_sel == SEL_CALL);
  assign w_pop      = mod_en & (w_sel == SEL_RET);
  assign w_conflict = mod_en & call & ret & ~we;

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_seq),
    .top       (w_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (w_ovf),
    .underflow (w_udf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctr      <= RESET_VEC;
      r_iaddr    <= RESET_VEC;
      r_err      <= 1'b0;
      r_misalign <= 1'b0;
    end else if (mod_en) begin
      r_iaddr    <= r_ctr;
      r_ctr      <= w_next;
      r_misalign <= |(w_next & MASK_W);
      if (w_ovf || w_udf || w_conflict) r_err <= 1'b1;
    end
  end

  assign iaddrout = r_iaddr;
  assign ras_err  = r_err;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        mod_en;
  logic        we;
  logic [31:0] wd;
  logic        ib;
  logic [31:0] bv;
  logic        call;
  logic        ret;
  logic [31:0] iaddrout;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;
  logic        misalign;

  int n_checks;
  int n_errors;

  pc_unit #(
    .WIDTH     (32),
    .STEP      (4),
    .RESET_VEC (32'h0),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mod_en    (mod_en),
    .we        (we),
    .wd        (wd),
    .ib        (ib),
    .bv        (bv),
    .call      (call),
    .ret       (ret),
    .iaddrout  (iaddrout),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err),
    .misalign  (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic i_we, input logic [31:0] i_wd, input logic i_ib,
                       input logic [31:0] i_bv, input logic i_call, input logic i_ret);
    we = i_we; wd = i_wd; ib = i_ib; bv = i_bv; call = i_call; ret = i_ret;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset  = 1'b0;
    mod_en = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check_eq("rst_iaddr",    iaddrout, 32'h0);
    check_eq("rst_empty",    32'(ras_empty), 32'd1);
    check_eq("rst_full",     32'(ras_full), 32'd0);
    check_eq("rst_err",      32'(ras_err), 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    #1 reset = 1'b1;

    // sequential run from the reset vector
    tick; check_eq("seq0", iaddrout, 32'h0);
    tick; check_eq("seq1", iaddrout, 32'h4);
    tick; check_eq("seq2", iaddrout, 32'h8);
    tick; check_eq("seq3", iaddrout, 32'hC);

    // negative relative branch
    drive(1, 32'h100, 0, 0, 0, 0); tick;
    drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0); tick;
    check_eq("br_iaddr_old", iaddrout, 32'h100);
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("br_iaddr_new", iaddrout, 32'hF8);
    check_eq("br_misalign",  32'(misalign), 32'd0);

    // sequential wrap past all-ones
    drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("wrap_pre", iaddrout, 32'hFFFF_FFFC);
    tick;
    check_eq("wrap_post", iaddrout, 32'h0);
    check_eq("wrap_misalign", 32'(misalign), 32'd0);

    // nested calls and returns
    drive(1, 32'h10, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 32'h30, 1, 0); tick;
    drive(0, 0, 0, 32'h40, 1, 0); tick;
    drive(0, 0, 0, 32'h100, 1, 0); tick;
    check_eq("nest_not_empty", 32'(ras_empty), 32'd0);
    drive(0, 0, 0, 0, 0, 1); tick;
    check_eq("nest_r1_iaddr", iaddrout, 32'h180);
    tick;
    check_eq("nest_r2_iaddr", iaddrout, 32'h84);
    tick;
    check_eq("nest_r3_iaddr", iaddrout, 32'h44);
    check_eq("nest_empty", 32'(ras_empty), 32'd1);
    check_eq("nest_err", 32'(ras_err), 32'd0);
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("nest_last_pop", iaddrout, 32'h14);

    // overflow then underflow
    drive(1, 32'h1000, 0, 0, 0, 0); tick;
    drive(0, 0, 0, 32'h100, 1, 0);
    for (int i = 0; i < 4; i++) tick;
    check_eq("ovf_full4", 32'(ras_full), 32'd1);
    check_eq("ovf_err4",  32'(ras_err), 32'd0);
    tick;
    check_eq("ovf_full5", 32'(ras_full), 32'd1);
    check_eq("ovf_err5",  32'(ras_err), 32'd1);
    drive(0, 0, 0, 0, 0, 1); tick;
    check_eq("ovf_r1", iaddrout, 32'h1500);
    tick; check_eq("ovf_r2", iaddrout, 32'h1404);
    tick; check_eq("ovf_r3", iaddrout, 32'h1304);
    tick; check_eq("ovf_r4", iaddrout, 32'h1204);
    check_eq("ovf_empty", 32'(ras_empty), 32'd1);
    tick; check_eq("udf_r5", iaddrout, 32'h1104);
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("udf_seq", iaddrout, 32'h1108);
    check_eq("udf_err", 32'(ras_err), 32'd1);

    // write beats call, then stall holds everything
    pulse_reset;
    check_eq("rst2_err", 32'(ras_err), 32'd0);
    drive(0, 0, 0, 32'h20, 1, 0); tick;
    drive(1, 32'h202, 0, 32'h40, 1, 0); tick;
    check_eq("pri_iaddr", iaddrout, 32'h20);
    check_eq("pri_misalign", 32'(misalign), 32'd1);
    check_eq("pri_full", 32'(ras_full), 32'd0);
    mod_en = 1'b0;
    drive(0, 0, 1, 32'h40, 0, 0); tick; tick;
    check_eq("stall_iaddr", iaddrout, 32'h20);
    check_eq("stall_misalign", 32'(misalign), 32'd1);
    check_eq("stall_empty", 32'(ras_empty), 32'd0);
    mod_en = 1'b1;
    drive(0, 0, 0, 0, 0, 1); tick;
    check_eq("pri_ret_iaddr", iaddrout, 32'h202);
    check_eq("pri_ret_misalign", 32'(misalign), 32'd0);
    check_eq("pri_ret_empty", 32'(ras_empty), 32'd1);
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("pri_ret_target", iaddrout, 32'h4);
    check_eq("pri_err", 32'(ras_err), 32'd0);

    // call and ret together: ret wins, error flagged
    drive(0, 0, 0, 32'h10, 1, 0); tick;
    drive(0, 0, 0, 32'h10, 1, 1); tick;
    check_eq("cr_err", 32'(ras_err), 32'd1);
    check_eq("cr_empty", 32'(ras_empty), 32'd1);
    drive(0, 0, 0, 0, 0, 0); tick;
    check_eq("cr_target", iaddrout, 32'hC);

    // asynchronous reset between edges after two pushes
    drive(0, 0, 0, 32'h40, 1, 0); tick; tick;
    check_eq("ar_pre_empty", 32'(ras_empty), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_iaddr", iaddrout, 32'h0);
    check_eq("ar_empty", 32'(ras_empty), 32'd1);
    check_eq("ar_err", 32'(ras_err), 32'd0);
    check_eq("ar_misalign", 32'(misalign), 32'd0);
    #1 reset = 1'b1;
    tick; check_eq("ar_seq0", iaddrout, 32'h0);
    tick; check_eq("ar_seq1", iaddrout, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
